edge_burst_gen: RTL and testbench

//  Transmit side of the edge-detect path: synthesizes a burst of clean rising edges
//  on WaveOut with programmable high/low widths, for downstream edge detectors.

---
 rtl/edge_burst_gen.sv | 150 +++++++++++++++
 tb/tb_edge_burst_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_burst_gen.sv
// -----------------------------------------------------------------------------
// edge_burst_gen
//   Transmit side of the edge-detect path. On request it emits a burst of
//   clean rising edges on WaveOut with programmable high and low widths. Each
//   rising edge is accompanied by a one-cycle Edge strobe. All outputs are
//   registered.
//
// Ports
//   Clock       in   1        system clock, all logic on posedge
//   ResetN      in   1        synchronous, active-low reset
//   Start       in   1        burst request, sampled only when idle
//   Abort       in   1        terminate burst in progress (wins over Start)
//   HighCycles  in   CNT_W    WaveOut high width in cycles (0 treated as 1)
//   LowCycles   in   CNT_W    WaveOut low width in cycles (0 treated as 1)
//   EdgeCount   in   BURST_W  number of rising edges to emit
//   WaveOut     out  1        generated waveform
//   Edge        out  1        pulse on the first cycle of each high phase
//   Busy        out  1        high while a burst is in progress
//   Done        out  1        pulse on the first idle cycle after normal completion
// -----------------------------------------------------------------------------
module edge_burst_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Start,
    input  logic               Abort,
    input  logic [CNT_W-1:0]   HighCycles,
    input  logic [CNT_W-1:0]   LowCycles,
    input  logic [BURST_W-1:0] EdgeCount,
    output logic               WaveOut,
    output logic               Edge,
    output logic               Busy,
    output logic               Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   high_reload_r;   // H-1, reloaded on every HIGH entry
    logic [CNT_W-1:0]   low_reload_r;    // L-1, reloaded on every LOW entry
    logic [CNT_W-1:0]   phase_cnt_r;     // cycles left in current phase, minus one
    logic [BURST_W-1:0] rem_r;           // rising edges still to be started
    logic               wave_r;
    logic               edge_r;
    logic               busy_r;
    logic               done_r;

    logic [CNT_W-1:0]   high_reload_s;
    logic [CNT_W-1:0]   low_reload_s;

    // Phase reload values: max(width,1)-1, so a zero width behaves like one cycle
    // and the all-ones width counts down without wrapping.
    always_comb begin
        high_reload_s = (HighCycles == '0) ? '0 : (HighCycles - CNT_W'(1));
        low_reload_s  = (LowCycles  == '0) ? '0 : (LowCycles  - CNT_W'(1));
    end

    // Burst FSM with registered outputs; Edge and Done default low so they pulse.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_r       <= ST_IDLE;
            high_reload_r <= '0;
            low_reload_r  <= '0;
            phase_cnt_r   <= '0;
            rem_r         <= '0;
            wave_r        <= 1'b0;
            edge_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            edge_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Start && !Abort) begin
                        if (EdgeCount != '0) begin
                            high_reload_r <= high_reload_s;
                            low_reload_r  <= low_reload_s;
                            phase_cnt_r   <= high_reload_s;
                            rem_r         <= EdgeCount;
                            state_r       <= ST_HIGH;
                            wave_r        <= 1'b1;
                            edge_r        <= 1'b1;
                            busy_r        <= 1'b1;
                        end else begin
                            // Empty burst completes immediately without an edge.
                            done_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_HIGH: begin
                    if (Abort) begin
                        state_r <= ST_IDLE;
                        wave_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (phase_cnt_r == '0) begin
                        // The edge just completed is counted on LOW entry.
                        state_r     <= ST_LOW;
                        phase_cnt_r <= low_reload_r;
                        rem_r       <= rem_r - BURST_W'(1);
                        wave_r      <= 1'b0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r - CNT_W'(1);
                    end
                end

                ST_LOW: begin
                    if (Abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (phase_cnt_r == '0) begin
                        if (rem_r != '0) begin
                            state_r     <= ST_HIGH;
                            phase_cnt_r <= high_reload_r;
                            wave_r      <= 1'b1;
                            edge_r      <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        phase_cnt_r <= phase_cnt_r - CNT_W'(1);
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    wave_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign WaveOut = wave_r;
    assign Edge    = edge_r;
    assign Busy    = busy_r;
    assign Done    = done_r;

endmodule

// File: tb/tb_edge_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_edge_burst_gen
//   Self-checking bench for edge_burst_gen. A table of per-cycle records
//   {inputs, expected outputs} covers reset, basic bursts, zero widths, empty
//   bursts, Abort/Start priority and reset mid-burst. Hand-written sequences
//   cover abort mid-burst followed by a full burst, back-to-back bursts with
//   Start held high, and a maximum-length burst.
//   Each record's inputs are driven, one rising edge elapses, and the outputs
//   {WaveOut, Edge, Busy, Done} are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_edge_burst_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] high_cycles;
    logic [7:0] low_cycles;
    logic [7:0] edge_count;
    logic       wave_out;
    logic       edge_pulse;
    logic       busy;
    logic       done;

    int total;
    int bad;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       abort;
        logic [7:0] high;
        logic [7:0] low;
        logic [7:0] count;
        logic [3:0] exp;   // {WaveOut, Edge, Busy, Done}
        string      name;
    } vec_t;

    vec_t vec_q[$];

    edge_burst_gen #(.CNT_W(8), .BURST_W(8)) dut (
        .Clock      (clk),
        .ResetN     (rst_n),
        .Start      (start),
        .Abort      (abort),
        .HighCycles (high_cycles),
        .LowCycles  (low_cycles),
        .EdgeCount  (edge_count),
        .WaveOut    (wave_out),
        .Edge       (edge_pulse),
        .Busy       (busy),
        .Done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic row(input logic r, input logic s, input logic a,
                       input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                       input logic [3:0] e, input string nm);
        vec_t v;
        v.rst_n = r; v.start = s; v.abort = a;
        v.high = h; v.low = l; v.count = n;
        v.exp = e; v.name = nm;
        vec_q.push_back(v);
    endtask

    task automatic check(input string nm, input logic [3:0] want);
        logic [3:0] got;
        got = {wave_out, edge_pulse, busy, done};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got wave/edge/busy/done=%b want=%b at %0t", nm, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs, let a rising edge pass, then compare.
    task automatic step(input logic s, input logic a, input logic [3:0] want, input string nm);
        start = s;
        abort = a;
        @(posedge clk);
        #1;
        check(nm, want);
    endtask

    initial begin
        int busy_cycles;
        int edge_pulses;
        bit finished;

        total = 0;
        bad   = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        high_cycles = 8'd0; low_cycles = 8'd0; edge_count = 8'd0;

        // Reset held with Start asserted: everything stays low.
        row(1'b0, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2, 4'b0000, "reset_c1");
        row(1'b0, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2, 4'b0000, "reset_c2");
        row(1'b0, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2, 4'b0000, "reset_c3");
        row(1'b1, 1'b0, 1'b0, 8'd2, 8'd3, 8'd2, 4'b0000, "idle_after_reset");
        // Basic H=2 L=3 N=2; inputs changed after latching must be ignored.
        row(1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2, 4'b1110, "basic_c1");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b1010, "basic_c2");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0010, "basic_c3");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0010, "basic_c4");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0010, "basic_c5");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b1110, "basic_c6");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b1010, "basic_c7");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0010, "basic_c8");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0010, "basic_c9");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0010, "basic_c10");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0001, "basic_done");
        row(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd9, 4'b0000, "basic_idle");
        // Zero widths H=0 L=0 N=4: one-cycle phases.
        row(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd4, 4'b1110, "zero_c1");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b0010, "zero_c2");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b1110, "zero_c3");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b0010, "zero_c4");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b1110, "zero_c5");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b0010, "zero_c6");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b1110, "zero_c7");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b0010, "zero_c8");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b0001, "zero_done");
        row(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd4, 4'b0000, "zero_idle");
        // Empty burst: Done only.
        row(1'b1, 1'b1, 1'b0, 8'd2, 8'd2, 8'd0, 4'b0001, "n0_done");
        row(1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 8'd0, 4'b0000, "n0_idle");
        // Abort and Start together in idle: request dropped, no Done.
        row(1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 8'd3, 4'b0000, "abort_wins_c1");
        row(1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 8'd3, 4'b0000, "abort_wins_c2");
        row(1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 8'd0, 4'b0000, "abort_wins_n0");
        // Reset mid-burst: WaveOut drops, no Done afterwards.
        row(1'b1, 1'b1, 1'b0, 8'd3, 8'd3, 8'd2, 4'b1110, "rstmid_c1");
        row(1'b1, 1'b0, 1'b0, 8'd3, 8'd3, 8'd2, 4'b1010, "rstmid_c2");
        row(1'b0, 1'b0, 1'b0, 8'd3, 8'd3, 8'd2, 4'b0000, "rstmid_rst");
        row(1'b1, 1'b0, 1'b0, 8'd3, 8'd3, 8'd2, 4'b0000, "rstmid_nodone");

        @(posedge clk);
        #1;
        for (int i = 0; i < vec_q.size(); i++) begin
            rst_n       = vec_q[i].rst_n;
            start       = vec_q[i].start;
            abort       = vec_q[i].abort;
            high_cycles = vec_q[i].high;
            low_cycles  = vec_q[i].low;
            edge_count  = vec_q[i].count;
            @(posedge clk);
            #1;
            check(vec_q[i].name, vec_q[i].exp);
        end

        // Abort in 2nd HIGH cycle of 2nd edge (H=4 L=4 N=3), then a full burst.
        rst_n = 1'b1;
        high_cycles = 8'd4; low_cycles = 8'd4; edge_count = 8'd3;
        step(1'b1, 1'b0, 4'b1110, "abort_k1");
        for (int k = 2; k <= 10; k++) begin
            int ph;
            ph = (k - 1) % 8;
            step(1'b0, 1'b0, {(ph < 4), (ph == 0), 1'b1, 1'b0}, $sformatf("abort_k%0d", k));
        end
        step(1'b0, 1'b1, 4'b0000, "abort_hit");
        step(1'b0, 1'b0, 4'b0000, "abort_nodone");
        step(1'b1, 1'b0, 4'b1110, "reburst_k1");
        for (int k = 2; k <= 24; k++) begin
            int ph;
            ph = (k - 1) % 8;
            step(1'b0, 1'b0, {(ph < 4), (ph == 0), 1'b1, 1'b0}, $sformatf("reburst_k%0d", k));
        end
        step(1'b0, 1'b0, 4'b0001, "reburst_done");
        step(1'b0, 1'b0, 4'b0000, "reburst_idle");

        // Start held high through H=1 L=1 N=2: one idle cycle between bursts.
        high_cycles = 8'd1; low_cycles = 8'd1; edge_count = 8'd2;
        step(1'b1, 1'b0, 4'b1110, "b2b_c1");
        step(1'b1, 1'b0, 4'b0010, "b2b_c2");
        step(1'b1, 1'b0, 4'b1110, "b2b_c3");
        step(1'b1, 1'b0, 4'b0010, "b2b_c4");
        step(1'b1, 1'b0, 4'b0001, "b2b_gap");
        step(1'b1, 1'b0, 4'b1110, "b2b_c6");
        step(1'b1, 1'b0, 4'b0010, "b2b_c7");
        step(1'b1, 1'b0, 4'b1110, "b2b_c8");
        step(1'b1, 1'b0, 4'b0010, "b2b_c9");
        step(1'b0, 1'b0, 4'b0001, "b2b_done2");
        step(1'b0, 1'b0, 4'b0000, "b2b_idle");

        // Maximum EdgeCount with 1-cycle phases: 255 edges, Busy for 510 cycles.
        high_cycles = 8'd0; low_cycles = 8'd0; edge_count = 8'd255;
        step(1'b1, 1'b0, 4'b1110, "max_start");
        start = 1'b0;
        busy_cycles = 1;
        edge_pulses = 1;
        finished = 1'b0;
        for (int k = 0; k < 1000 && !finished; k++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                busy_cycles++;
                if (edge_pulse) edge_pulses++;
            end else begin
                finished = 1'b1;
            end
        end
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL max_timeout: busy still high after 1000 cycles, want low by 510");
        end
        total++;
        if (busy_cycles != 510) begin
            bad++;
            $display("FAIL max_busy_len: got=%0d want=510", busy_cycles);
        end
        total++;
        if (edge_pulses != 255) begin
            bad++;
            $display("FAIL max_edges: got=%0d want=255", edge_pulses);
        end
        check("max_done", 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
